// File: rtl/pcm_tx_scheduler.sv
// pcm_tx_scheduler: arbitrates mic/music PCM words into a FIFO and
// issues one word per sample tick to the SPI transmitter.
module pcm_tx_scheduler #(
  parameter int CLK_DIV    = 375,
  parameter int FIFO_DEPTH = 8,
  parameter int STRETCH    = 8,
  parameter int CS_TIMEOUT = 300
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  mode,
  input  logic [15:0]                 mic_data,
  input  logic                        mic_valid,
  output logic                        mic_ready,
  input  logic [15:0]                 mus_data,
  input  logic                        mus_valid,
  output logic                        mus_ready,
  output logic [15:0]                 pcm_data,
  output logic                        pcm_valid,
  input  logic                        cs_n,
  input  logic                        status_clr,
  output logic                        underrun,
  output logic                        cs_timeout,
  output logic                        tick_miss,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam int SW = $clog2(STRETCH + 1);
  localparam int TW = $clog2(CS_TIMEOUT + 1);

  localparam logic [CW-1:0] TICK_LAST = CW'(CLK_DIV - 1);
  localparam logic [SW-1:0] STR_LAST  = SW'(STRETCH - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(CS_TIMEOUT - 1);
  localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_WAIT_LOW,
    S_WAIT_HIGH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] str_q, str_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          cs_s1_q, cs_s2_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rr_q, rr_d;
  logic [15:0]   pcm_data_q, pcm_data_d;
  logic          pcm_valid_q, pcm_valid_d;
  logic          underrun_q, underrun_d;
  logic          cs_timeout_q, cs_timeout_d;
  logic          tick_miss_q, tick_miss_d;
  logic [15:0]   mem_q [FIFO_DEPTH];

  logic        tick;
  logic        full;
  logic        empty;
  logic        mic_rdy;
  logic        mus_rdy;
  logic        push_mic;
  logic        push_mus;
  logic        push;
  logic [15:0] push_data;
  logic        pop;
  logic        underrun_set;
  logic        timeout_set;
  logic        tick_miss_set;

  assign tick  = (cnt_q == TICK_LAST);
  assign full  = (count_q == FULL_LVL);
  assign empty = (count_q == '0);

  // rr_q=0: mic wins the next contested cycle
  always_comb begin
    mic_rdy = 1'b0;
    mus_rdy = 1'b0;
    unique case (mode)
      2'd0: mic_rdy = !full;
      2'd1: mus_rdy = !full;
      2'd2: begin
        if (mic_valid && mus_valid) begin
          mic_rdy = !full && !rr_q;
          mus_rdy = !full && rr_q;
        end else begin
          mic_rdy = !full && mic_valid;
          mus_rdy = !full && mus_valid;
        end
      end
      default: ;
    endcase
  end

  assign push_mic  = mic_valid && mic_rdy;
  assign push_mus  = mus_valid && mus_rdy;
  assign push      = push_mic || push_mus;
  assign push_data = push_mic ? mic_data : mus_data;

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    rr_d  = rr_q;
    if (mode == 2'd2 && push)
      rr_d = push_mic;
  end

  always_comb begin
    state_d       = state_q;
    str_d         = str_q;
    tmo_d         = tmo_q;
    pcm_data_d    = pcm_data_q;
    pcm_valid_d   = pcm_valid_q;
    pop           = 1'b0;
    underrun_set  = 1'b0;
    timeout_set   = 1'b0;
    tick_miss_set = tick && (state_q != S_IDLE);
    if (state_q == S_IDLE) begin
      if (tick && !empty) begin
        pop         = 1'b1;
        pcm_data_d  = mem_q[rd_ptr_q];
        pcm_valid_d = 1'b1;
        str_d       = '0;
        tmo_d       = '0;
        state_d     = S_PULSE;
      end else if (tick) begin
        underrun_set = 1'b1;
      end
    end else begin
      tmo_d = tmo_q + TW'(1);
      if (tmo_q == TMO_LAST) begin
        timeout_set = 1'b1;
        pcm_valid_d = 1'b0;
        state_d     = S_IDLE;
      end else if (state_q == S_PULSE) begin
        if (str_q == STR_LAST) begin
          pcm_valid_d = 1'b0;
          state_d     = S_WAIT_LOW;
        end else begin
          str_d = str_q + SW'(1);
        end
      end else if (state_q == S_WAIT_LOW) begin
        if (!cs_s2_q)
          state_d = S_WAIT_HIGH;
      end else if (cs_s2_q) begin
        state_d = S_IDLE;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // a new event wins over a clear in the same cycle
  always_comb begin
    underrun_d   = underrun_set || (underrun_q && !status_clr);
    cs_timeout_d = timeout_set || (cs_timeout_q && !status_clr);
    tick_miss_d  = tick_miss_set || (tick_miss_q && !status_clr);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      str_q        <= '0;
      tmo_q        <= '0;
      cs_s1_q      <= 1'b1;
      cs_s2_q      <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rr_q         <= 1'b0;
      pcm_data_q   <= '0;
      pcm_valid_q  <= 1'b0;
      underrun_q   <= 1'b0;
      cs_timeout_q <= 1'b0;
      tick_miss_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      str_q        <= str_d;
      tmo_q        <= tmo_d;
      cs_s1_q      <= cs_n;
      cs_s2_q      <= cs_s1_q;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rr_q         <= rr_d;
      pcm_data_q   <= pcm_data_d;
      pcm_valid_q  <= pcm_valid_d;
      underrun_q   <= underrun_d;
      cs_timeout_q <= cs_timeout_d;
      tick_miss_q  <= tick_miss_d;
    end
  end

  assign mic_ready  = mic_rdy;
  assign mus_ready  = mus_rdy;
  assign pcm_data   = pcm_data_q;
  assign pcm_valid  = pcm_valid_q;
  assign underrun   = underrun_q;
  assign cs_timeout = cs_timeout_q;
  assign tick_miss  = tick_miss_q;
  assign fifo_level = count_q;

endmodule

// File: tb/tb_pcm_tx_scheduler.sv
// tb_pcm_tx_scheduler: directed + random stimulus against a queue-based
// reference model; issued words are checked by a separate monitor.
module tb_pcm_tx_scheduler;

  localparam int CLK_DIV = 375;
  localparam int DEPTH   = 8;
  localparam int STRETCH = 8;
  localparam int CS_TMO  = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [15:0] mic_data = '0;
  logic        mic_valid = 1'b0;
  logic        mic_ready;
  logic [15:0] mus_data = '0;
  logic        mus_valid = 1'b0;
  logic        mus_ready;
  logic [15:0] pcm_data;
  logic        pcm_valid;
  logic        cs_n = 1'b1;
  logic        status_clr = 1'b0;
  logic        underrun;
  logic        cs_timeout;
  logic        tick_miss;
  logic [3:0]  fifo_level;

  pcm_tx_scheduler dut (
    .clk(clk), .reset(reset), .mode(mode),
    .mic_data(mic_data), .mic_valid(mic_valid),
    .mic_ready(mic_ready),
    .mus_data(mus_data), .mus_valid(mus_valid),
    .mus_ready(mus_ready),
    .pcm_data(pcm_data), .pcm_valid(pcm_valid),
    .cs_n(cs_n), .status_clr(status_clr),
    .underrun(underrun), .cs_timeout(cs_timeout),
    .tick_miss(tick_miss), .fifo_level(fifo_level)
  );

  // short-period build so a tick can land while a word is in flight
  logic        reset2 = 1'b1;
  logic [15:0] mic_data2 = '0;
  logic        mic_valid2 = 1'b0;
  logic        mic_ready2, mus_ready2, pcm_valid2;
  logic [15:0] pcm_data2;
  logic        underrun2, cs_timeout2, tick_miss2;
  logic [3:0]  fifo_level2;

  pcm_tx_scheduler #(
    .CLK_DIV(64), .FIFO_DEPTH(8),
    .STRETCH(8), .CS_TIMEOUT(100)
  ) dut2 (
    .clk(clk), .reset(reset2), .mode(2'd0),
    .mic_data(mic_data2), .mic_valid(mic_valid2),
    .mic_ready(mic_ready2),
    .mus_data(16'h0), .mus_valid(1'b0),
    .mus_ready(mus_ready2),
    .pcm_data(pcm_data2), .pcm_valid(pcm_valid2),
    .cs_n(1'b1), .status_clr(1'b0),
    .underrun(underrun2), .cs_timeout(cs_timeout2),
    .tick_miss(tick_miss2), .fifo_level(fifo_level2)
  );

  int checks = 0;
  int failures = 0;
  bit done2 = 1'b0;

  task automatic chk(input string name, input int act,
                     input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, expv, $time);
    end
  endtask

  // stimulus knobs for the next cycle
  bit          s_reset = 1'b1;
  logic [1:0]  s_mode = 2'd0;
  bit          s_mic_v, s_mus_v, s_clr;
  logic [15:0] s_mic_d, s_mus_d;
  int          np_kind, np_d1 = 20, np_len = 40;

  // reference model state (as seen after the latest edge)
  logic [15:0] mq[$];
  logic [15:0] exp_q[$];
  bit          rr_mus, m_under, m_tmo, m_miss, busy;
  int          k, pv_left, age, plan, d1, len;

  task automatic step();
    bit full, er_mic, er_mus, push_mic, push_mus;
    bit tick, pop, tmo_set;
    @(negedge clk);
    chk("fifo_level", int'(fifo_level), mq.size());
    chk("pcm_valid", int'(pcm_valid), int'(pv_left > 0));
    chk("underrun", int'(underrun), int'(m_under));
    chk("cs_timeout", int'(cs_timeout), int'(m_tmo));
    chk("tick_miss", int'(tick_miss), int'(m_miss));
    reset      = s_reset;
    mode       = s_mode;
    mic_valid  = s_mic_v;
    mus_valid  = s_mus_v;
    mic_data   = s_mic_d;
    mus_data   = s_mus_d;
    status_clr = s_clr;
    cs_n = !(busy && plan == 0 && age >= d1 && age < d1 + len);
    #1;
    if (s_reset) begin
      mq.delete();
      rr_mus = 0; m_under = 0; m_tmo = 0; m_miss = 0;
      busy = 0; k = 0; pv_left = 0; age = 0;
      return;
    end
    full = mq.size() >= DEPTH;
    er_mic = 0;
    er_mus = 0;
    case (s_mode)
      2'd0: er_mic = !full;
      2'd1: er_mus = !full;
      2'd2: begin
        if (s_mic_v && s_mus_v) begin
          er_mic = !full && !rr_mus;
          er_mus = !full && rr_mus;
        end else begin
          er_mic = !full && s_mic_v;
          er_mus = !full && s_mus_v;
        end
      end
      default: ;
    endcase
    if (s_mode != 2'd2 || s_mic_v)
      chk("mic_ready", int'(mic_ready), int'(er_mic));
    if (s_mode != 2'd2 || s_mus_v)
      chk("mus_ready", int'(mus_ready), int'(er_mus));
    push_mic = s_mic_v && er_mic;
    push_mus = s_mus_v && er_mus;
    tick = (k == CLK_DIV - 1);
    pop = tick && !busy && mq.size() > 0;
    tmo_set = busy && plan == 1 && age == CS_TMO - 1;
    m_under = (tick && !busy && mq.size() == 0)
              || (m_under && !s_clr);
    m_tmo  = tmo_set || (m_tmo && !s_clr);
    m_miss = (tick && busy) || (m_miss && !s_clr);
    if (busy) begin
      if (tmo_set || (plan == 0 && age > d1 + len + 4))
        busy = 0;
      age++;
    end
    if (pv_left > 0)
      pv_left--;
    if (pop) begin
      exp_q.push_back(mq.pop_front());
      pv_left = STRETCH;
      busy = 1; age = 0;
      plan = np_kind; d1 = np_d1; len = np_len;
    end
    if (push_mic) mq.push_back(s_mic_d);
    if (push_mus) mq.push_back(s_mus_d);
    if (s_mode == 2'd2 && (push_mic || push_mus))
      rr_mus = push_mic;
    k = (k + 1) % CLK_DIV;
  endtask

  initial begin : monitor
    logic prev;
    logic [15:0] w;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (pcm_valid && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pcm_data: unexpected word %0h, none due",
                   pcm_data);
        end else begin
          w = exp_q.pop_front();
          chk("pcm_data", int'(pcm_data), int'(w));
        end
      end
      prev = pcm_valid;
    end
  end

  initial begin : miss_test
    repeat (2) @(negedge clk);
    reset2 = 1'b0;
    mic_valid2 = 1'b1;
    mic_data2 = 16'h1234;
    @(negedge clk);
    mic_valid2 = 1'b0;
    repeat (119) @(negedge clk);
    chk("dut2_tick_miss_early", int'(tick_miss2), 0);
    chk("dut2_cs_timeout_early", int'(cs_timeout2), 0);
    chk("dut2_pcm_data", int'(pcm_data2), 16'h1234);
    repeat (50) @(negedge clk);
    chk("dut2_tick_miss", int'(tick_miss2), 1);
    chk("dut2_cs_timeout", int'(cs_timeout2), 1);
    done2 = 1'b1;
  end

  initial begin : main
    int rate;
    s_mic_d = '0;
    s_mus_d = '0;
    np_kind = 0;
    // reset
    repeat (3) step();
    chk("pcm_data_reset", int'(pcm_data), 0);
    s_reset = 0;
    // single mic word with a normal cs_n cycle
    s_mode = 2'd0;
    s_mic_v = 1; s_mic_d = 16'hA5C3;
    step();
    s_mic_v = 0;
    repeat (CLK_DIV + 150) step();
    // round-robin fill and refill
    s_mode = 2'd2;
    s_mic_v = 1; s_mic_d = 16'h1111;
    s_mus_v = 1; s_mus_d = 16'h2222;
    repeat (2 * CLK_DIV) step();
    // underrun, clear, and set beating clear
    s_mic_v = 0; s_mus_v = 0;
    s_reset = 1;
    step();
    s_reset = 0;
    s_mode = 2'd3;
    s_mic_v = 1; s_mus_v = 1;
    repeat (CLK_DIV + 2) step();
    s_clr = 1;
    step();
    s_clr = 0;
    step();
    while (k != CLK_DIV - 1) step();
    s_clr = 1;
    step();
    s_clr = 0;
    repeat (3) step();
    // no cs_n activity -> timeout
    s_mic_v = 0; s_mus_v = 0;
    s_mode = 2'd0;
    s_mic_v = 1; s_mic_d = 16'hBEEF;
    step();
    s_mic_v = 0;
    np_kind = 1;
    repeat (CLK_DIV + 310) step();
    // reset on the 4th pulse cycle
    np_kind = 0;
    s_mic_v = 1; s_mic_d = 16'hCAFE;
    step();
    s_mic_d = 16'hD00D;
    step();
    s_mic_v = 0;
    while (k != CLK_DIV - 1) step();
    repeat (4) step();
    s_reset = 1;
    step();
    s_reset = 0;
    repeat (4) step();
    // randomized traffic
    rate = 32;
    for (int c = 0; c < 12 * CLK_DIV; c++) begin
      if (c % 250 == 0) begin
        s_mode = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 2))
          0: rate = 1;
          1: rate = 32;
          default: rate = 64;
        endcase
      end
      s_mic_v = $urandom_range(0, 63) < rate;
      s_mus_v = $urandom_range(0, 63) < rate;
      s_mic_d = 16'($urandom);
      s_mus_d = 16'($urandom);
      s_clr = ($urandom_range(0, 49) == 0);
      np_kind = ($urandom_range(0, 3) == 0) ? 1 : 0;
      np_d1 = $urandom_range(12, 60);
      np_len = $urandom_range(5, 60);
      step();
    end
    s_mic_v = 0; s_mus_v = 0; s_clr = 0;
    repeat (2) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("dut2_test_done", int'(done2), 1);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
